// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, keyboard command bytes and
// the microsecond-to-cycle conversion used to size the timers.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_SEND     = 3'd2,
        ST_ACK      = 3'd3,
        ST_WAITIDLE = 3'd4
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_ACK        = 8'hFA;

    // 64-bit math: TIMEOUT_US * CLK_HZ overflows 32 bits at the defaults.
    function automatic longint ps2_cycles(input longint us, input longint clk_hz);
        return (us * clk_hz) / 64'sd1_000_000;
    endfunction

    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 pin plus a one-cycle falling-edge
// strobe. Resets to the idle-high level so reset release never fakes a fall.
module ps2_line_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    // Synchronizer chain and one-cycle history for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_meta   <= i_line;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_sync_d & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, shift the
// frame on device clock falls, check the ACK, guarded by a frame watchdog.
module ps2_host_tx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kbdclk_in,
    input  logic       kbddat_in,
    output logic       kbdclk_pull,
    output logic       kbddat_pull,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy
);
    import ps2_pkg::*;

    localparam int INH_CYC = int'(ps2_cycles(longint'(INHIBIT_US), longint'(CLK_HZ)));
    localparam int TO_CYC  = int'(ps2_cycles(longint'(TIMEOUT_US), longint'(CLK_HZ)));
    localparam int INH_W   = $clog2(INH_CYC + 1);
    localparam int WD_W    = $clog2(TO_CYC + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);
    localparam logic [INH_W-1:0] INH_FULL = INH_W'(INH_CYC);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TO_CYC - 1);
    localparam logic [WD_W-1:0]  WD_FULL  = WD_W'(TO_CYC);
    localparam logic [3:0]       BIT_PAR  = 4'd8;
    localparam logic [3:0]       BIT_STOP = 4'd9;
    localparam logic [3:0]       BIT_MAX  = 4'd15;

    logic w_clk_sync;
    logic w_clk_fall;
    logic w_dat_sync;
    logic w_unused_dat_fall;

    ps2_line_sync u_clk_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_line  (kbdclk_in),
        .o_sync  (w_clk_sync),
        .o_fall  (w_clk_fall)
    );

    ps2_line_sync u_dat_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_line  (kbddat_in),
        .o_sync  (w_dat_sync),
        .o_fall  (w_unused_dat_fall)
    );

    ps2_tx_state_e    r_state;
    logic [7:0]       r_byte;
    logic             r_parity;
    logic [INH_W-1:0] r_inh_cnt;
    logic [WD_W-1:0]  r_wd_cnt;
    logic [3:0]       r_bitcnt;
    logic             r_ack_ok;
    logic             r_clk_pull;
    logic             r_dat_pull;
    logic             r_done;
    logic             r_err;
    logic             r_ready;
    logic             r_busy;

    ps2_tx_state_e    w_state_nxt;
    logic [7:0]       w_byte_nxt;
    logic             w_parity_nxt;
    logic [INH_W-1:0] w_inh_nxt;
    logic [WD_W-1:0]  w_wd_nxt;
    logic [3:0]       w_bit_nxt;
    logic             w_ack_nxt;
    logic             w_clk_pull_nxt;
    logic             w_dat_pull_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic             w_wd_expire;

    assign w_wd_expire = (r_state != ST_IDLE) && (r_wd_cnt == WD_LAST);

    // State register and all datapath/output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_byte     <= 8'h00;
            r_parity   <= 1'b0;
            r_inh_cnt  <= {INH_W{1'b0}};
            r_wd_cnt   <= {WD_W{1'b0}};
            r_bitcnt   <= 4'd0;
            r_ack_ok   <= 1'b0;
            r_clk_pull <= 1'b0;
            r_dat_pull <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte     <= w_byte_nxt;
            r_parity   <= w_parity_nxt;
            r_inh_cnt  <= w_inh_nxt;
            r_wd_cnt   <= w_wd_nxt;
            r_bitcnt   <= w_bit_nxt;
            r_ack_ok   <= w_ack_nxt;
            r_clk_pull <= w_clk_pull_nxt;
            r_dat_pull <= w_dat_pull_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_ready    <= (w_state_nxt == ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state and next-output logic; watchdog expiry overrides any clock fall.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_nxt     = r_byte;
        w_parity_nxt   = r_parity;
        w_inh_nxt      = r_inh_cnt;
        w_bit_nxt      = r_bitcnt;
        w_ack_nxt      = r_ack_ok;
        w_clk_pull_nxt = r_clk_pull;
        w_dat_pull_nxt = r_dat_pull;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        if ((r_state != ST_IDLE) && (r_wd_cnt != WD_FULL)) begin
            w_wd_nxt = r_wd_cnt + 1'b1;
        end else begin
            w_wd_nxt = r_wd_cnt;
        end

        if (w_wd_expire) begin
            w_state_nxt    = ST_IDLE;
            w_clk_pull_nxt = 1'b0;
            w_dat_pull_nxt = 1'b0;
            w_done_nxt     = 1'b1;
            w_err_nxt      = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_clk_pull_nxt = 1'b0;
                    w_dat_pull_nxt = 1'b0;
                    if (tx_valid) begin
                        w_state_nxt    = ST_INHIBIT;
                        w_byte_nxt     = tx_data;
                        w_parity_nxt   = ps2_odd_parity(tx_data);
                        w_inh_nxt      = {INH_W{1'b0}};
                        w_wd_nxt       = {WD_W{1'b0}};
                        w_bit_nxt      = 4'd0;
                        w_ack_nxt      = 1'b0;
                        w_clk_pull_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_INHIBIT: begin
                    // Start bit goes out one cycle before the clock is released.
                    if (r_inh_cnt == INH_FULL) begin
                        w_clk_pull_nxt = 1'b0;
                        w_bit_nxt      = 4'd0;
                        w_state_nxt    = ST_SEND;
                    end else if (r_inh_cnt == INH_LAST) begin
                        w_dat_pull_nxt = 1'b1;
                        w_inh_nxt      = r_inh_cnt + 1'b1;
                    end else begin
                        w_inh_nxt      = r_inh_cnt + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (w_clk_fall) begin
                        if (r_bitcnt == BIT_MAX) begin
                            w_bit_nxt = r_bitcnt;
                        end else begin
                            w_bit_nxt = r_bitcnt + 4'd1;
                        end
                        if (r_bitcnt < BIT_PAR) begin
                            w_dat_pull_nxt = ~r_byte[r_bitcnt[2:0]];
                        end else if (r_bitcnt == BIT_PAR) begin
                            w_dat_pull_nxt = ~r_parity;
                        end else begin
                            w_dat_pull_nxt = 1'b0;
                        end
                        if (r_bitcnt >= BIT_STOP) begin
                            w_state_nxt = ST_ACK;
                        end else begin
                            w_state_nxt = ST_SEND;
                        end
                    end else begin
                        w_state_nxt = ST_SEND;
                    end
                end
                ST_ACK: begin
                    if (w_clk_fall) begin
                        w_ack_nxt      = ~w_dat_sync;
                        w_dat_pull_nxt = 1'b0;
                        w_state_nxt    = ST_WAITIDLE;
                    end else begin
                        w_state_nxt    = ST_ACK;
                    end
                end
                ST_WAITIDLE: begin
                    if (w_clk_sync && w_dat_sync) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = ~r_ack_ok;
                    end else begin
                        w_state_nxt = ST_WAITIDLE;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_clk_pull_nxt = 1'b0;
                    w_dat_pull_nxt = 1'b0;
                end
            endcase
        end
    end

    assign kbdclk_pull = r_clk_pull;
    assign kbddat_pull = r_dat_pull;
    assign tx_ready    = r_ready;
    assign tx_done     = r_done;
    assign tx_err      = r_err;
    assign busy        = r_busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-drain lines with pullups and a
// behavioural keyboard that clocks frames, samples bits and optionally ACKs.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       kbdclk_in;
    logic       kbddat_in;
    logic       kbdclk_pull;
    logic       kbddat_pull;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       busy;

    logic        dev_clk_low = 1'b0;
    logic        dev_dat_low = 1'b0;
    logic [10:0] sampled;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         stall;
        bit         hold;
        bit         exp_err;
        bit         exp_par;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    assign kbdclk_in = ~(kbdclk_pull | dev_clk_low);
    assign kbddat_in = ~(kbddat_pull | dev_dat_low);

    ps2_host_tx #(
        .CLK_HZ     (1_000_000),
        .INHIBIT_US (100),
        .TIMEOUT_US (15_000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .kbdclk_in   (kbdclk_in),
        .kbddat_in   (kbddat_in),
        .kbdclk_pull (kbdclk_pull),
        .kbddat_pull (kbddat_pull),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .busy        (busy)
    );

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Expected line levels seen by the device: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic wait_request(output bit ok);
        int c;
        c = 0;
        ok = 1'b0;
        while (!ok && c < 1000) begin
            if (kbdclk_in === 1'b1 && kbddat_in === 1'b0) ok = 1'b1;
            else begin
                @(negedge clk);
                c++;
            end
        end
    endtask

    task automatic dev_pulse(output logic s);
        dev_clk_low = 1'b1;
        repeat (30) @(negedge clk);
        dev_clk_low = 1'b0;
        s = kbddat_in;
        repeat (30) @(negedge clk);
    endtask

    task automatic device_run(input bit ack, input bit stall);
        bit   ok;
        logic s;
        wait_request(ok);
        check("request_seen", ok, 1);
        if (ok && !stall) begin
            sampled[0] = kbddat_in;
            repeat (20) @(negedge clk);
            for (int i = 1; i <= 10; i++) begin
                dev_pulse(s);
                sampled[i] = s;
            end
            repeat (15) @(negedge clk);
            if (ack) dev_dat_low = 1'b1;
            repeat (15) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (30) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (5) @(negedge clk);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input bit stall,
                             input bit hold, input bit exp_err);
        logic [10:0] exp_f;
        int   c;
        int   t;
        int   ready_seen;
        int   dones;
        bit   done_seen;
        logic err_v;
        exp_f   = frame_model(d);
        sampled = 11'h7FF;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
        check("accept_state", {busy, tx_ready, kbdclk_pull}, 3'b101);
        fork
            device_run(ack, stall);
            begin
                c = 0;
                while (!kbddat_pull && c < 1000) begin
                    @(negedge clk);
                    c++;
                end
                check("inhibit_cycles", c, 100);
                t = c;
                c = 0;
                while (kbdclk_pull && c < 10) begin
                    @(negedge clk);
                    c++;
                end
                check("start_to_clk_release", c, 1);
                t = t + c;
                done_seen  = 1'b0;
                ready_seen = 0;
                err_v      = 1'b0;
                while (!done_seen && t < 20000) begin
                    if (tx_ready) ready_seen++;
                    @(negedge clk);
                    t++;
                    if (tx_done) begin
                        done_seen = 1'b1;
                        err_v     = tx_err;
                    end
                end
                check("done_seen", done_seen, 1);
                check("done_err", err_v, exp_err);
                check("ready_low_in_frame", ready_seen, 0);
                check("pulls_at_done", {kbdclk_pull, kbddat_pull}, 2'b00);
                if (stall) check("timeout_cycles", t, 15000);
            end
        join
        if (!stall) begin
            for (int i = 0; i < 11; i++) check($sformatf("frame_bit%0d", i), sampled[i], exp_f[i]);
        end
        if (hold) begin
            @(negedge clk);
            check("hold_second_accept", {busy, kbdclk_pull}, 2'b11);
            tx_valid = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            repeat (20) @(negedge clk);
        end else begin
            dones = 0;
            repeat (100) begin
                @(negedge clk);
                if (tx_done) dones++;
            end
            check("single_done", dones, 0);
            check("pulls_idle", {kbdclk_pull, kbddat_pull, tx_ready}, 3'b001);
        end
    endtask

    initial begin
        bit         ok;
        bit         ack;
        logic       s;
        logic [7:0] d;
        int         dones;

        vecs[0] = '{PS2_CMD_SETLED, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h00,          1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h01,          1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{PS2_CMD_ENABLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{PS2_CMD_RESET,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'hAA,          1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_outputs", {kbdclk_pull, kbddat_pull, tx_ready, tx_done, tx_err, busy}, 6'b001000);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_outputs", {kbdclk_pull, kbddat_pull, tx_ready, tx_done, busy}, 5'b00100);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].data, vecs[i].ack, vecs[i].stall, vecs[i].hold, vecs[i].exp_err);
            if (!vecs[i].stall) check("table_parity", sampled[9], vecs[i].exp_par);
        end

        for (int i = 0; i < 6; i++) begin
            d   = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 3) != 0);
            run_frame(d, ack, 1'b0, 1'b0, !ack);
        end

        // Reset after four device clock falls, then a clean frame.
        @(negedge clk);
        tx_data  = PS2_CMD_SETLED;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_request(ok);
        check("mid_request_seen", ok, 1);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++) dev_pulse(s);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_state", {kbdclk_pull, kbddat_pull, tx_ready, tx_done, busy}, 5'b00100);
        dones = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_done) dones++;
        end
        check("mid_reset_no_done", dones, 0);
        run_frame(PS2_CMD_RESET, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
